// File: rtl/spi_deserializer.sv
// spi_deserializer
//   Receive side of the SPI link. Samples sclk/mosi (asynchronous to clk),
//   assembles DATAWIDTH-bit words MSB-first on sclk rising edges and hands
//   each completed word to the RX FIFO through a single-cycle write strobe.
//
// Ports
//   clk        system clock, all registers on its rising edge
//   rst_n      asynchronous active-low reset
//   sclk       SPI serial clock (asynchronous)
//   mosi       SPI serial data (asynchronous)
//   full       RX FIFO full flag, sampled only on the final-bit sclk rise
//   writeData  last word written to the FIFO, held between writes
//   writeEn    one-cycle FIFO write strobe
//   overflow   one-cycle pulse: completed word dropped because FIFO full
//   frame_err  one-cycle pulse: partial word dropped after sclk went idle
//   busy       high while a word is partially received

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef BIT_COUNTER_WIDTH
`define BIT_COUNTER_WIDTH 4
`endif

module spi_deserializer #(
  parameter int DATAWIDTH       = `DATA_WIDTH,
  parameter int BITCOUNTERWIDTH = `BIT_COUNTER_WIDTH,
  parameter int TIMEOUT         = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 full,
  output logic [DATAWIDTH-1:0] writeData,
  output logic                 writeEn,
  output logic                 overflow,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int IDLEW = $clog2(TIMEOUT + 1);
  localparam logic [BITCOUNTERWIDTH-1:0] LAST_CNT   = BITCOUNTERWIDTH'(DATAWIDTH);
  localparam logic [IDLEW-1:0]           IDLE_LIMIT = IDLEW'(TIMEOUT - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                   state;
  logic                     sclk_m, sclk_s, sclk_d;
  logic                     mosi_m, mosi_s;
  logic                     rise;
  // The final bit of a word is taken straight from mosi_s, so only the
  // DATAWIDTH-1 earlier bits need to be held.
  logic [DATAWIDTH-2:0]     shift_reg;
  logic [DATAWIDTH-1:0]     shift_next;
  logic [BITCOUNTERWIDTH-1:0] bit_cnt;
  logic [BITCOUNTERWIDTH-1:0] bit_cnt_inc;
  logic [IDLEW-1:0]         idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_d <= 1'b0;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
    end
  end

  always_comb begin
    rise        = sclk_s & ~sclk_d;
    shift_next  = {shift_reg, mosi_s};
    bit_cnt_inc = bit_cnt + 1'b1;
    busy        = (state == RECV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      writeData <= '0;
      writeEn   <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      writeEn   <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      if (rise) begin
        shift_reg <= shift_next[DATAWIDTH-2:0];
      end
      case (state)
        IDLE: begin
          if (rise) begin
            bit_cnt  <= BITCOUNTERWIDTH'(1);
            idle_cnt <= '0;
            state    <= RECV;
          end
        end
        RECV: begin
          if (rise) begin
            idle_cnt <= '0;
            if (bit_cnt_inc == LAST_CNT) begin
              bit_cnt <= '0;
              state   <= IDLE;
              if (full) begin
                overflow <= 1'b1;
              end else begin
                writeData <= shift_next;
                writeEn   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt_inc;
            end
          end else if (idle_cnt == IDLE_LIMIT) begin
            frame_err <= 1'b1;
            bit_cnt   <= '0;
            shift_reg <= '0;
            idle_cnt  <= '0;
            state     <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_deserializer.sv
// tb_spi_deserializer
//   Drives SPI frames (directed and random) into spi_deserializer and checks
//   every output event (kind, cycle, data) against a queue of expected events
//   computed from the bits sent, plus reset and busy behaviour.

`timescale 1ns/1ps

module tb_spi_deserializer;

  localparam int DW   = 8;
  localparam int TO   = 64;
  localparam int K_WE = 1;
  localparam int K_OV = 2;
  localparam int K_FE = 3;

  typedef struct {
    int          kind;
    int          data;
    int unsigned at;
  } ev_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk  = 1'b0;
  logic          mosi  = 1'b0;
  logic          full  = 1'b0;
  logic [DW-1:0] writeData;
  logic          writeEn;
  logic          overflow;
  logic          frame_err;
  logic          busy;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  int          model_data = 0;
  ev_t         exp_q[$];

  spi_deserializer #(
    .DATAWIDTH(DW),
    .BITCOUNTERWIDTH(4),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .mosi(mosi),
    .full(full),
    .writeData(writeData),
    .writeEn(writeEn),
    .overflow(overflow),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every pulse seen on the output side must match the oldest expected event.
  always @(negedge clk) begin
    ev_t e;
    int  kind;
    if (rst_n && (writeEn || overflow || frame_err)) begin
      kind = writeEn ? K_WE : (overflow ? K_OV : K_FE);
      check("pulse_onehot", $countones({writeEn, overflow, frame_err}), 1);
      check("event_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        check("event_cycle", cyc, e.at);
        check("event_data", writeData, e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the top nbits of word MSB-first with a 4-cycle sclk period.
  // A pin rise driven after edge c is consumed at edge c+3, so a completed
  // word reports at c+3 and an abandoned one TIMEOUT cycles later.
  task automatic send_word(input logic [DW-1:0] word, input int nbits,
                           input logic fv, input bit track);
    int unsigned c = 0;
    ev_t e;
    full = fv;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[DW-1-i];
      tick(1);
      sclk = 1'b1;
      c = cyc;
      if (i == 2) check("busy_mid", busy, 1);
      tick(2);
      sclk = 1'b0;
      tick(1);
    end
    if (track) begin
      if (nbits == DW) begin
        if (fv) begin
          e = '{K_OV, model_data, c + 3};
        end else begin
          model_data = int'(word);
          e = '{K_WE, int'(word), c + 3};
        end
      end else begin
        e = '{K_FE, model_data, c + 3 + TO};
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      tick(1);
      n++;
    end
    check(tag, exp_q.size(), 0);
    tick(2);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          nb;
    logic [DW-1:0] w;
    logic        fv;

    // Reset held while the pins toggle
    rst_n = 1'b0;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      sclk = i[0];
      mosi = 1'($urandom_range(0, 1));
      tick(2);
      check("rst_outputs", {writeData, writeEn, overflow, frame_err, busy}, 0);
    end
    sclk = 1'b0;
    mosi = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_data", writeData, 0);

    // Single word
    send_word(8'hA5, DW, 1'b0, 1'b1);
    drain("drain_a5");

    // Back-to-back words, no gap
    send_word(8'h3C, DW, 1'b0, 1'b1);
    send_word(8'hC3, DW, 1'b0, 1'b1);
    drain("drain_b2b");

    // Overflow keeps writeData, next word lands normally
    send_word(8'hFF, DW, 1'b1, 1'b1);
    drain("drain_ovf");
    send_word(8'h01, DW, 1'b0, 1'b1);
    drain("drain_01");

    // Timeout after 5 bits, then recovery
    send_word(8'hB7, 5, 1'b0, 1'b1);
    drain("drain_timeout");
    send_word(8'h5A, DW, 1'b0, 1'b1);
    drain("drain_5a");

    // Reset mid-word
    send_word(8'hF0, 4, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("rst_async_busy", busy, 0);
    check("rst_async_data", writeData, 0);
    model_data = 0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    send_word(8'h81, DW, 1'b0, 1'b1);
    drain("drain_81");

    // Random mix of words, full, gaps and abandoned partial words
    for (int k = 0; k < 24; k++) begin
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, DW - 1)) : DW;
      w  = DW'($urandom);
      fv = ($urandom_range(0, 3) == 0);
      send_word(w, nb, fv, 1'b1);
      if (nb < DW) drain("drain_rand_partial");
      else if ($urandom_range(0, 1) == 1) tick(int'($urandom_range(0, 3)));
    end
    drain("drain_rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
